// File: rtl/sram_wrap_pkg.sv
// sram_wrap_pkg: shared types and width helpers for the SRAM request controller
package sram_wrap_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_e;
   typedef enum logic {OP_WR, OP_RD} op_e;
   function automatic int int_mem_w(input int row_w);
      return row_w / 2;
   endfunction
   function automatic int int_mem_addr_w(input int row_addr_w);
      return row_addr_w + 1;
   endfunction
endpackage

// File: rtl/sram_wrap_ctrl.sv
// sram_wrap_ctrl: splits row req/val traffic into two half-width strobed SRAM port accesses
// Ports: clk/rst (sync, active-high); wr_req/rd_req/addr/wr_data in, req_ready out;
// rd_data/rd_data_val/addr_err out; I1/I2/A1/A2 and active-low CEB/WEB/OEB/CSB to the
// array, O1/O2 read data from it. Every pin output comes straight from a flop.
module sram_wrap_ctrl
   import sram_wrap_pkg::*;
#(
   parameter int SRAM_WRAP_WIDTH  = 32,
   parameter int SRAM_WRAP_DEPTH  = 100,
   parameter int SRAM_WRAP_ADDR_W = $clog2(SRAM_WRAP_DEPTH),
   parameter int INT_MEM_W        = int_mem_w(SRAM_WRAP_WIDTH),
   parameter int INT_MEM_ADDR_W   = int_mem_addr_w(SRAM_WRAP_ADDR_W)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr_req,
   input  logic                        rd_req,
   input  logic [SRAM_WRAP_ADDR_W-1:0] addr,
   input  logic [SRAM_WRAP_WIDTH-1:0]  wr_data,
   output logic                        req_ready,
   output logic [SRAM_WRAP_WIDTH-1:0]  rd_data,
   output logic                        rd_data_val,
   output logic                        addr_err,
   output logic [INT_MEM_W-1:0]        I1,
   output logic [INT_MEM_W-1:0]        I2,
   input  logic [INT_MEM_W-1:0]        O1,
   input  logic [INT_MEM_W-1:0]        O2,
   output logic                        CEB1,
   output logic                        CEB2,
   output logic                        WEB1,
   output logic                        WEB2,
   output logic                        OEB1,
   output logic                        OEB2,
   output logic                        CSB1,
   output logic                        CSB2,
   output logic [INT_MEM_ADDR_W-1:0]   A1,
   output logic [INT_MEM_ADDR_W-1:0]   A2
);
   state_e                      state_q, state_d;
   op_e                         op_q, op_d;
   logic                        oor_q, oor_d;
   logic                        req_ready_q, req_ready_d;
   logic [SRAM_WRAP_WIDTH-1:0]  rd_data_q, rd_data_d;
   logic                        rd_data_val_q, rd_data_val_d;
   logic                        addr_err_q, addr_err_d;
   logic [INT_MEM_W-1:0]        i1_q, i1_d, i2_q, i2_d;
   logic [INT_MEM_ADDR_W-1:0]   a1_q, a1_d, a2_q, a2_d;
   logic                        ceb_q, ceb_d, web_q, web_d, oeb_q, oeb_d, csb_q, csb_d;

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      oor_d         = oor_q;
      rd_data_d     = rd_data_q;
      rd_data_val_d = 1'b0;
      addr_err_d    = 1'b0;
      i1_d          = i1_q;
      i2_d          = i2_q;
      a1_d          = a1_q;
      a2_d          = a2_q;
      csb_d         = 1'b1;
      web_d         = 1'b1;
      oeb_d         = 1'b1;
      case (state_q)
         IDLE: if ((wr_req | rd_req) & req_ready_q) begin
            state_d = SETUP;
            op_d    = wr_req ? OP_WR : OP_RD;
            oor_d   = {1'b0, addr} >= (SRAM_WRAP_ADDR_W + 1)'(SRAM_WRAP_DEPTH);
            a1_d    = {addr, 1'b0};
            a2_d    = {addr, 1'b1};
            i1_d    = wr_data[INT_MEM_W-1:0];
            i2_d    = wr_data[SRAM_WRAP_WIDTH-1:INT_MEM_W];
         end
         SETUP: state_d = STROBE;
         STROBE: begin
            state_d       = IDLE;
            addr_err_d    = oor_q;
            rd_data_val_d = op_q == OP_RD;
            rd_data_d     = op_q != OP_RD ? rd_data_q : oor_q ? '0 : {O2, O1};
         end
         default: state_d = IDLE;
      endcase
      // Out-of-range accesses still walk the FSM but keep the array deselected.
      if (state_d != IDLE) begin
         csb_d = oor_d;
         web_d = op_d != OP_WR;
         oeb_d = op_d != OP_RD;
      end
      ceb_d       = state_d == STROBE;
      req_ready_d = state_d == IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         op_q          <= OP_WR;
         oor_q         <= 1'b0;
         req_ready_q   <= 1'b0;
         rd_data_q     <= '0;
         rd_data_val_q <= 1'b0;
         addr_err_q    <= 1'b0;
         i1_q          <= '0;
         i2_q          <= '0;
         a1_q          <= '0;
         a2_q          <= '0;
         ceb_q         <= 1'b0;
         web_q         <= 1'b1;
         oeb_q         <= 1'b1;
         csb_q         <= 1'b1;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         oor_q         <= oor_d;
         req_ready_q   <= req_ready_d;
         rd_data_q     <= rd_data_d;
         rd_data_val_q <= rd_data_val_d;
         addr_err_q    <= addr_err_d;
         i1_q          <= i1_d;
         i2_q          <= i2_d;
         a1_q          <= a1_d;
         a2_q          <= a2_d;
         ceb_q         <= ceb_d;
         web_q         <= web_d;
         oeb_q         <= oeb_d;
         csb_q         <= csb_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign rd_data     = rd_data_q;
   assign rd_data_val = rd_data_val_q;
   assign addr_err    = addr_err_q;
   assign I1          = i1_q;
   assign I2          = i2_q;
   assign A1          = a1_q;
   assign A2          = a2_q;
   assign CEB1        = ceb_q;
   assign CEB2        = ceb_q;
   assign WEB1        = web_q;
   assign WEB2        = web_q;
   assign OEB1        = oeb_q;
   assign OEB2        = oeb_q;
   assign CSB1        = csb_q;
   assign CSB2        = csb_q;
endmodule

// File: tb/tb_sram_wrap_ctrl.sv
// tb_sram_wrap_ctrl: directed bench pairing sram_wrap_ctrl with a behavioural flop array
module tb_sram_wrap_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_req = 1'b0, rd_req = 1'b0;
   logic [6:0]  addr = '0;
   logic [31:0] wr_data = '0;
   logic        req_ready, rd_data_val, addr_err;
   logic [31:0] rd_data;
   logic [15:0] I1, I2;
   logic [15:0] O1 = '0, O2 = '0;
   logic        CEB1, CEB2, WEB1, WEB2, OEB1, OEB2, CSB1, CSB2;
   logic [7:0]  A1, A2;
   logic [15:0] mem [0:255];
   int          n_checks = 0, n_err = 0;

   sram_wrap_ctrl dut (
      .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req), .addr(addr),
      .wr_data(wr_data), .req_ready(req_ready), .rd_data(rd_data),
      .rd_data_val(rd_data_val), .addr_err(addr_err), .I1(I1), .I2(I2),
      .O1(O1), .O2(O2), .CEB1(CEB1), .CEB2(CEB2), .WEB1(WEB1), .WEB2(WEB2),
      .OEB1(OEB1), .OEB2(OEB2), .CSB1(CSB1), .CSB2(CSB2), .A1(A1), .A2(A2)
   );

   always #5 clk = ~clk;

   always @(posedge CEB1) if (!CSB1) begin
      if (!WEB1) mem[A1] <= I1;
      if (!OEB1) O1 <= mem[A1];
   end
   always @(posedge CEB2) if (!CSB2) begin
      if (!WEB2) mem[A2] <= I2;
      if (!OEB2) O2 <= mem[A2];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic do_write(input logic [6:0] a, input logic [31:0] d);
      wr_req = 1'b1; addr = a; wr_data = d;
      chk("wr_ready_c0", req_ready, 1);
      cyc();
      wr_req = 1'b0;
      chk("wr_ready_c1", req_ready, 0);
      chk("wr_A1", A1, 32'(a) * 2);
      chk("wr_A2", A2, 32'(a) * 2 + 1);
      chk("wr_I1", I1, d[15:0]);
      chk("wr_I2", I2, d[31:16]);
      chk("wr_WEB", {WEB1, WEB2, OEB1, OEB2, CEB1}, 5'b00110);
      chk("wr_CSB", {CSB1, CSB2}, a >= 100 ? 2'b11 : 2'b00);
      cyc();
      chk("wr_ready_c2", req_ready, 0);
      chk("wr_CEB", {CEB1, CEB2}, 2'b11);
      cyc();
   endtask

   task automatic do_read(input logic [6:0] a, input logic [31:0] exp);
      rd_req = 1'b1; addr = a;
      chk("rd_ready_c0", req_ready, 1);
      cyc();
      rd_req = 1'b0;
      chk("rd_ready_c1", req_ready, 0);
      chk("rd_A1", A1, 32'(a) * 2);
      chk("rd_A2", A2, 32'(a) * 2 + 1);
      chk("rd_ctrl", {WEB1, WEB2, OEB1, OEB2, CEB1}, 5'b11000);
      chk("rd_CSB_c1", {CSB1, CSB2}, a >= 100 ? 2'b11 : 2'b00);
      cyc();
      chk("rd_ready_c2", req_ready, 0);
      chk("rd_CEB", {CEB1, CEB2}, 2'b11);
      chk("rd_CSB_c2", {CSB1, CSB2}, a >= 100 ? 2'b11 : 2'b00);
      chk("rd_val_c2", rd_data_val, 0);
      cyc();
      chk("rd_val_c3", rd_data_val, 1);
      chk("rd_data", rd_data, exp);
      chk("rd_err_c3", addr_err, a >= 100);
      chk("rd_ready_c3", req_ready, 1);
      chk("rd_idle_ctrl", {CSB1, WEB1, OEB1, CEB1}, 4'b1110);
   endtask

   initial begin
      cyc();
      cyc();
      chk("rst_ready", req_ready, 0);
      chk("rst_ctrl", {CSB1, CSB2, WEB1, WEB2, OEB1, OEB2, CEB1, CEB2}, 8'b11111100);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_pulses", {rd_data_val, addr_err}, 0);
      chk("rst_AI", {A1, A2, I1}, 0);
      rst = 1'b0;
      cyc();
      chk("ready_after_rst", req_ready, 1);
      do_write(7'd5, 32'hDEADBEEF);
      do_read(7'd5, 32'hDEADBEEF);
      cyc();
      chk("val_pulse_end", rd_data_val, 0);
      wr_req = 1'b1; rd_req = 1'b1; addr = 7'd7; wr_data = 32'h12345678;
      cyc();
      wr_req = 1'b0;
      chk("both_write_wins", {WEB1, OEB1}, 2'b01);
      cyc();
      cyc();
      chk("both_ready_c3", req_ready, 1);
      chk("both_no_val", rd_data_val, 0);
      do_read(7'd7, 32'h12345678);
      cyc();
      for (int i = 0; i < 100; i++) do_write(7'(i), 32'h9E3779B9 * (i + 1));
      for (int i = 0; i < 100; i++) do_read(7'(i), 32'h9E3779B9 * (i + 1));
      cyc();
      do_read(7'd100, 32'h0);
      cyc();
      chk("err_pulse_end", {addr_err, rd_data_val}, 0);
      do_write(7'd3, 32'h11112222);
      wr_req = 1'b1; addr = 7'd3; wr_data = 32'hAAAA5555;
      cyc();
      wr_req = 1'b0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("midrst_ready", req_ready, 0);
      chk("midrst_ctrl", {CSB1, CSB2, WEB1, WEB2, OEB1, OEB2, CEB1, CEB2}, 8'b11111100);
      chk("midrst_AI", {A1, I1, I2}, 0);
      chk("midrst_rd_data", rd_data, 0);
      cyc();
      chk("midrst_ready_up", req_ready, 1);
      do_read(7'd3, 32'h11112222);
      cyc();
      rd_req = 1'b1; addr = 7'd5;
      cyc();
      rd_req = 1'b0;
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rd_rst_no_val", rd_data_val, 0);
      cyc();
      chk("rd_rst_no_val2", rd_data_val, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
